gradient_stream: RTL and testbench

GRADIENT_STREAM -- requirements
Module: gradient_stream

---
 rtl/gradient_stream.sv | 178 +++++++++++++++++
 tb/tb_gradient_stream.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_stream.sv
// Streaming 3x3-neighbourhood gradient: central differences with edge replication,
// L1 magnitude and a 9-bin unsigned orientation, under valid/ready on both sides.
module gradient_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 128
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [PIX_W-1:0]        iPixel,
    output logic                    oValid,
    input  logic                    iReady,
    output logic signed [PIX_W:0]   oDx,
    output logic signed [PIX_W:0]   oDy,
    output logic [PIX_W:0]          oMag,
    output logic [3:0]              oBin,
    output logic                    oLast
);

    localparam int DEPTH = 2 * IMG_W + 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NPIX + 1);
    localparam int RW    = $clog2(IMG_H + 1);
    localparam int CLW   = $clog2(IMG_W);
    localparam int MW    = PIX_W + 12;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    in_cnt_q, k_q;
    logic [AW-1:0]    wp_q, rp_q, left_a, right_a, up_a;
    logic [AW:0]      up_sum;
    logic [RW-1:0]    row_q;
    logic [CLW-1:0]   col_q;
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] c_pix, l_pix, r_pix, u_pix, d_pix;

    logic             in_xfer, end_frame, produce;
    logic signed [PIX_W:0] dx, dy;
    logic [PIX_W:0]   adx, ady, mag;
    logic [MW-1:0]    lhs, adx_w;
    logic             nb0, nb1, nb2, nb3;
    logic [2:0]       fold;
    logic [3:0]       bin;

    always_comb begin
        unique case (state_q)
            IDLE, FILL: oReady = 1'b1;
            RUN:        oReady = !oValid || iReady;
            default:    oReady = 1'b0;
        endcase
    end

    assign in_xfer   = iValid && oReady;
    assign end_frame = oValid && iReady && oLast;

    // The transfer that completes a window below the current output triggers its computation.
    always_comb begin
        produce = 1'b0;
        if (in_xfer && (state_q == RUN || (state_q == FILL && in_cnt_q == CW'(IMG_W))))
            produce = 1'b1;
        if (state_q == FLUSH && (!oValid || iReady) && k_q != CW'(NPIX))
            produce = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_xfer) state_d = FILL;
            FILL:  if (in_xfer && in_cnt_q == CW'(IMG_W)) state_d = RUN;
            RUN:   if (in_xfer && in_cnt_q == CW'(NPIX - 1)) state_d = FLUSH;
            default: if (end_frame) state_d = IDLE;
        endcase
    end

    always_comb begin
        left_a  = (rp_q == '0) ? AW'(DEPTH - 1) : rp_q - 1'b1;
        right_a = (rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
        up_sum  = {1'b0, rp_q} + (AW+1)'(DEPTH - IMG_W);
        if (up_sum >= (AW+1)'(DEPTH)) up_sum = up_sum - (AW+1)'(DEPTH);
        up_a    = up_sum[AW-1:0];
    end

    // Neighbour below is the pixel arriving right now; only the last row replicates it.
    always_comb begin
        c_pix = mem[rp_q];
        l_pix = (col_q == '0) ? c_pix : mem[left_a];
        r_pix = (col_q == CLW'(IMG_W - 1)) ? c_pix : mem[right_a];
        u_pix = (row_q == '0) ? c_pix : mem[up_a];
        d_pix = (row_q == RW'(IMG_H - 1)) ? c_pix : iPixel;
    end

    always_comb begin
        dx    = $signed({1'b0, r_pix}) - $signed({1'b0, l_pix});
        dy    = $signed({1'b0, d_pix}) - $signed({1'b0, u_pix});
        adx   = dx[PIX_W] ? (~dx + (PIX_W+1)'(1)) : dx;
        ady   = dy[PIX_W] ? (~dy + (PIX_W+1)'(1)) : dy;
        mag   = adx + ady;
        lhs   = MW'(ady) << 8;
        adx_w = MW'(adx);
        nb0   = !(lhs < adx_w * MW'(93));
        nb1   = !(lhs < adx_w * MW'(215));
        nb2   = !(lhs < adx_w * MW'(443));
        nb3   = !(lhs < adx_w * MW'(1452));
        fold  = 3'(nb0) + 3'(nb1) + 3'(nb2) + 3'(nb3);
        if (dx == '0 && dy == '0)
            bin = 4'd0;
        else if (dx != '0 && dy != '0 && dx[PIX_W] != dy[PIX_W])
            bin = 4'd8 - {1'b0, fold};
        else
            bin = {1'b0, fold};
    end

    // History is not reset; counters guarantee no stale entry is ever read.
    always_ff @(posedge iClk) begin
        if (in_xfer) mem[wp_q] <= iPixel;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            in_cnt_q <= '0;
            k_q      <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            oValid   <= 1'b0;
            oDx      <= '0;
            oDy      <= '0;
            oMag     <= '0;
            oBin     <= '0;
            oLast    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (end_frame) begin
                in_cnt_q <= '0;
                k_q      <= '0;
                wp_q     <= '0;
                rp_q     <= '0;
                row_q    <= '0;
                col_q    <= '0;
            end else begin
                if (in_xfer) begin
                    in_cnt_q <= in_cnt_q + 1'b1;
                    wp_q     <= (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
                end
                if (produce) begin
                    k_q  <= k_q + 1'b1;
                    rp_q <= right_a;
                    if (col_q == CLW'(IMG_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
            if (produce) begin
                oValid <= 1'b1;
                oDx    <= dx;
                oDy    <= dy;
                oMag   <= mag;
                oBin   <= bin;
                oLast  <= (k_q == CW'(NPIX - 1));
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gradient_stream.sv
// Directed bench for gradient_stream on a 4x3 frame: constant, ramps, diagonals,
// backpressure and mid-frame reset.
module tb_gradient_stream;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready_dut, out_valid, out_ready, out_last;
    logic [7:0]        in_pixel;
    logic signed [8:0] out_dx, out_dy;
    logic [8:0]        out_mag;
    logic [3:0]        out_bin;

    int errors = 0;
    int checks = 0;

    logic [7:0]        pix     [12];
    logic signed [8:0] got_dx  [12];
    logic signed [8:0] got_dy  [12];
    logic [8:0]        got_mag [12];
    logic [3:0]        got_bin [12];
    logic              got_last[12];
    int n_out, flush_outs, flush_ready, stall_bad, stall_cycles;

    gradient_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(3)) dut (
        .iClk(clk), .iRst(rst), .iValid(in_valid), .oReady(in_ready_dut),
        .iPixel(in_pixel), .oValid(out_valid), .iReady(out_ready),
        .oDx(out_dx), .oDy(out_dy), .oMag(out_mag), .oBin(out_bin), .oLast(out_last)
    );

    always #5 clk = ~clk;

    // Streams pix[] in, collects outputs; optional 5-cycle iReady stall in RUN.
    task automatic run_frame(input bit stall);
        int in_idx = 0;
        int cyc = 0;
        int st_left = 0;
        bit stall_done = 1'b0;
        logic signed [8:0] s_dx, s_dy;
        logic [8:0] s_mag;
        logic [3:0] s_bin;
        n_out = 0; flush_outs = 0; flush_ready = 0; stall_bad = 0; stall_cycles = 0;
        while (n_out < 12 && cyc < 300) begin
            @(negedge clk);
            in_valid = (in_idx < 12);
            in_pixel = (in_idx < 12) ? pix[in_idx] : 8'd0;
            if (stall && !stall_done && st_left == 0 && n_out == 2 && out_valid) begin
                st_left = 5;
                s_dx = out_dx; s_dy = out_dy; s_mag = out_mag; s_bin = out_bin;
            end
            out_ready = (st_left == 0);
            #1;
            if (st_left > 0) begin
                stall_cycles++;
                if (!out_valid || in_ready_dut || out_dx !== s_dx || out_dy !== s_dy ||
                    out_mag !== s_mag || out_bin !== s_bin) stall_bad++;
                st_left--;
                if (st_left == 0) stall_done = 1'b1;
            end
            if (in_idx == 12 && in_ready_dut) flush_ready++;
            if (out_valid && out_ready) begin
                got_dx[n_out] = out_dx; got_dy[n_out] = out_dy; got_mag[n_out] = out_mag;
                got_bin[n_out] = out_bin; got_last[n_out] = out_last;
                if (in_idx == 12) flush_outs++;
                n_out++;
            end
            if (in_valid && in_ready_dut) in_idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready_dut !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready_dut); end
        checks++; if (out_dx !== 9'sd0 || out_dy !== 9'sd0 || out_mag !== 9'd0 || out_bin !== 4'd0 || out_last !== 1'b0) begin
            errors++; $display("FAIL reset_fields: got dx=%0d dy=%0d mag=%0d bin=%0d last=%b expected all 0",
                               out_dx, out_dy, out_mag, out_bin, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_constant();
        for (int i = 0; i < 12; i++) pix[i] = 8'd100;
        run_frame(1'b0);
        checks++; if (n_out !== 12) begin errors++; $display("FAIL const_count: got %0d expected 12", n_out); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got_dx[i] !== 9'sd0 || got_dy[i] !== 9'sd0 || got_mag[i] !== 9'd0 || got_bin[i] !== 4'd0) begin
                errors++; $display("FAIL const_out[%0d]: got dx=%0d dy=%0d mag=%0d bin=%0d expected all 0",
                                   i, got_dx[i], got_dy[i], got_mag[i], got_bin[i]);
            end
            checks++; if (got_last[i] !== (i == 11)) begin errors++; $display("FAIL const_last[%0d]: got %b expected %b", i, got_last[i], i == 11); end
        end
        checks++; if (flush_outs !== 5) begin errors++; $display("FAIL const_flush_outs: got %0d expected 5", flush_outs); end
        checks++; if (flush_ready !== 0) begin errors++; $display("FAIL const_flush_ready: got %0d cycles with oReady=1 expected 0", flush_ready); end
    endtask

    task automatic check_hramp(input string tag);
        logic signed [8:0] e_dx;
        checks++; if (n_out !== 12) begin errors++; $display("FAIL %s_count: got %0d expected 12", tag, n_out); end
        for (int i = 0; i < 12; i++) begin
            e_dx = (i % 4 == 0 || i % 4 == 3) ? 9'sd10 : 9'sd20;
            checks++;
            if (got_dx[i] !== e_dx || got_dy[i] !== 9'sd0 || got_mag[i] !== 9'(e_dx) || got_bin[i] !== 4'd0) begin
                errors++; $display("FAIL %s_out[%0d]: got dx=%0d dy=%0d mag=%0d bin=%0d expected dx=%0d dy=0 mag=%0d bin=0",
                                   tag, i, got_dx[i], got_dy[i], got_mag[i], got_bin[i], e_dx, e_dx);
            end
        end
        checks++; if (got_last[11] !== 1'b1 || got_last[10] !== 1'b0) begin
            errors++; $display("FAIL %s_last: got last10=%b last11=%b expected 0 1", tag, got_last[10], got_last[11]);
        end
    endtask

    task automatic test_hramp();
        for (int i = 0; i < 12; i++) pix[i] = 8'(10 * (i % 4));
        run_frame(1'b0);
        check_hramp("hramp");
    endtask

    task automatic test_vramp();
        logic signed [8:0] e_dy;
        for (int i = 0; i < 12; i++) pix[i] = 8'(10 * (i / 4));
        run_frame(1'b0);
        checks++; if (n_out !== 12) begin errors++; $display("FAIL vramp_count: got %0d expected 12", n_out); end
        for (int i = 0; i < 12; i++) begin
            e_dy = (i / 4 == 1) ? 9'sd20 : 9'sd10;
            checks++;
            if (got_dx[i] !== 9'sd0 || got_dy[i] !== e_dy || got_mag[i] !== 9'(e_dy) || got_bin[i] !== 4'd4) begin
                errors++; $display("FAIL vramp_out[%0d]: got dx=%0d dy=%0d mag=%0d bin=%0d expected dx=0 dy=%0d mag=%0d bin=4",
                                   i, got_dx[i], got_dy[i], got_mag[i], got_bin[i], e_dy, e_dy);
            end
        end
    endtask

    // anti=1: P = 20 + 10c - 10r (dy negative); anti=0: P = 10c + 10r.
    task automatic test_diag(input bit anti);
        logic signed [8:0] e_dx, e_dy;
        logic [8:0] e_mag;
        logic [3:0] e_bin;
        for (int i = 0; i < 12; i++)
            pix[i] = anti ? 8'(20 + 10 * (i % 4) - 10 * (i / 4)) : 8'(10 * (i % 4) + 10 * (i / 4));
        run_frame(1'b0);
        checks++; if (n_out !== 12) begin errors++; $display("FAIL diag%0d_count: got %0d expected 12", anti, n_out); end
        for (int i = 0; i < 12; i++) begin
            e_dx = (i % 4 == 0 || i % 4 == 3) ? 9'sd10 : 9'sd20;
            e_dy = (i / 4 == 1) ? 9'sd20 : 9'sd10;
            e_mag = 9'(e_dx) + 9'(e_dy);
            // Equal magnitudes -> 45 deg; 10/20 -> 63.4 deg; 20/10 -> 26.6 deg.
            if (e_dx == e_dy) e_bin = anti ? 4'd6 : 4'd2;
            else if (e_dx < e_dy) e_bin = anti ? 4'd5 : 4'd3;
            else e_bin = anti ? 4'd7 : 4'd1;
            if (anti) e_dy = -e_dy;
            checks++;
            if (got_dx[i] !== e_dx || got_dy[i] !== e_dy || got_mag[i] !== e_mag || got_bin[i] !== e_bin) begin
                errors++; $display("FAIL diag%0d_out[%0d]: got dx=%0d dy=%0d mag=%0d bin=%0d expected dx=%0d dy=%0d mag=%0d bin=%0d",
                                   anti, i, got_dx[i], got_dy[i], got_mag[i], got_bin[i], e_dx, e_dy, e_mag, e_bin);
            end
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 12; i++) pix[i] = 8'(10 * (i % 4));
        run_frame(1'b1);
        checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stall_cycles); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
        check_hramp("stall");
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'(55 + 30 * i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready_dut !== 1'b1 || out_mag !== 9'd0 || out_last !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got valid=%b ready=%b mag=%0d last=%b expected 0 1 0 0",
                               out_valid, in_ready_dut, out_mag, out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) pix[i] = 8'd100;
        run_frame(1'b0);
        checks++; if (n_out !== 12) begin errors++; $display("FAIL midrst_count: got %0d expected 12", n_out); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (got_mag[i] !== 9'd0 || got_last[i] !== (i == 11)) begin
                errors++; $display("FAIL midrst_out[%0d]: got mag=%0d last=%b expected mag=0 last=%b",
                                   i, got_mag[i], got_last[i], i == 11);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_hramp();
        test_vramp();
        test_diag(1'b1);
        test_diag(1'b0);
        test_back_pressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
